mmio_initiator: RTL
===================

# mmio_initiator

Bus-mastering front end for the memory-mapped peripheral bus used by the PWM register block. It accepts read/write commands from a host through a valid/ready queue and drives them onto the `addr/data/wr/rd` strobes, one transaction at a time. It collects `rd_valid` read data, or flags a timeout, and returns one response per read through a valid/ready port. It sits between a test host or CPU shim and any MMIO responder, such as the PWM block at base `0xBBBB_0000`.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 16: read-wait cycles before a timeout response; 1..255.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid_in`  in  1  host command valid.
- `cmd_ready_out`  out  1  FIFO can accept; equals !full.
- `cmd_write_in`  in  1  1 = write, 0 = read.
- `cmd_addr_in`  in  32  target address.
- `cmd_data_in`  in  32  write data; ignored for reads.
- `rsp_valid_out`  out  1  read response valid.
- `rsp_ready_in`  in  1  host accepts response.
- `rsp_data_out`  out  32  read data; 0 on timeout.
- `rsp_timeout_out`  out  1  response produced by timeout.
- `timeout_count_out`  out  16  saturating count of read timeouts.
- `bus_addr_out`  out  32  to responder `addr_in`.
- `bus_data_out`  out  32  to responder `data_in`.
- `bus_wr_out`  out  1  to responder `wr_in`.
- `bus_rd_out`  out  1  to responder `rd_in`.
- `bus_rd_valid_in`  in  1  from responder `rd_valid_out`.
- `bus_data_in`  in  32  from responder `data_out`.

## Operation
**Command FIFO**
- Push when `cmd_valid_in && cmd_ready_out`.
- `cmd_ready_out` depends only on the registered occupancy. When full, a same-cycle pop does not enable a push.
- Push and pop in the same cycle are legal when not full; occupancy is unchanged.

**FSM states**
- IDLE: if the FIFO is non-empty, pop the head and register the bus outputs.
  - Write command: go to WRITE.
  - Read command: go to READ.
- WRITE: `bus_wr_out`=1 for this cycle only, then go to IDLE.
- READ: `bus_rd_out`=1 for this cycle only; clear the wait counter; go to WAIT.
- WAIT: increment the wait counter each cycle.
  - If `bus_rd_valid_in`=1: capture `bus_data_in` into `rsp_data_out`, set `rsp_timeout_out`=0, go to RESP.
  - Otherwise, if the wait counter reaches `TIMEOUT_CYCLES`: set `rsp_data_out`=0 and `rsp_timeout_out`=1, increment `timeout_count_out` (saturating at 0xFFFF), go to RESP.
  - If valid arrives in the timeout cycle, valid wins.
- RESP: `rsp_valid_out`=1. Data and flag are held stable until `rsp_ready_in`=1, then go to IDLE.

**Bus-side rules**
- `bus_rd_valid_in` outside WAIT is ignored. It does not change the captured data or the counter.
- `bus_addr_out` and `bus_data_out` hold their last values between transactions.
- For reads, `bus_data_out` keeps its previous value.
- `bus_wr_out` and `bus_rd_out` are never high together, and never high for two consecutive cycles.
- At most one transaction is outstanding; there is no pipelining.
- Writes generate no response.

## Timing
**Reset**
- All outputs go to 0.
- Exception: `cmd_ready_out`=1 in the first cycle after reset.
- FIFO is emptied; FSM goes to IDLE; `timeout_count_out` goes to 0.
- Reset in any state, including WAIT and RESP, aborts the transaction and drops any pending response.

**Cycle numbering**
- Command pushed in cycle P is visible to IDLE in cycle P+1.
- Pop in cycle T puts the strobe in cycle T+1.

**Writes**
- One write costs 2 cycles (IDLE, WRITE).
- Back-to-back writes produce strobes every 2 cycles.

**Reads**
- Against a 1-cycle responder: strobe at T+1, `bus_rd_valid_in` at T+2, `rsp_valid_out` from T+3.
- Response latency from pop: 3 cycles, plus any host backpressure.
- Timeout: `rsp_valid_out` rises `TIMEOUT_CYCLES`+2 cycles after the pop.

## Test plan
- **Write then read-back:** push write `0xBBBB_0004` / `0x0000_1234`, then read `0xBBBB_0004` against the PWM MMIO block.
  - Required: one `bus_wr_out` pulse with that addr/data.
  - Required: response `0x0000_1234`, timeout=0, `rsp_valid_out` 3 cycles after the read pop.
- **Read timeout:** tie `bus_rd_valid_in`=0, read `0xBBBB_0000`.
  - Required: `rsp_valid_out` at pop+18 with `TIMEOUT_CYCLES`=16; data 0; timeout=1; `timeout_count_out`=1.
- **FIFO full and backpressure:** hold `rsp_ready_in`=0 and push 6 reads.
  - Required: 5 accepted (1 in flight plus 4 queued), then `cmd_ready_out`=0.
  - Required: response data held stable.
  - Release `rsp_ready_in`: 5 responses arrive in order, addresses match.
- **Stray valid:** pulse `bus_rd_valid_in` with data `0xFFFF_FFFF` while in IDLE.
  - Required: no response; the next read returns the correct value.
- **Reset mid-WAIT:** assert `rst` 1 cycle after the read strobe.
  - Required: all outputs 0 next cycle, no response, FIFO empty, `cmd_ready_out`=1.
- **Valid-vs-timeout tie:** `bus_rd_valid_in` with data `0xA5A5_A5A5` arrives in cycle 16 of WAIT.
  - Required: response `0xA5A5_A5A5`, timeout=0, counter unchanged.

Source files
------------

// File: rtl/mmio_initiator.sv
// rtl/mmio_initiator.sv - single-outstanding MMIO bus master with command FIFO and read responses
module mmio_initiator #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic        cmd_write_in,
  input  logic [31:0] cmd_addr_in,
  input  logic [31:0] cmd_data_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_data_out,
  output logic        rsp_timeout_out,
  output logic [15:0] timeout_count_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_data_out,
  output logic        bus_wr_out,
  output logic        bus_rd_out,
  input  logic        bus_rd_valid_in,
  input  logic [31:0] bus_data_in
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(CMD_DEPTH);
  localparam logic [7:0] TMO_L = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  // Each entry: {write flag, address, write data}
  logic [64:0]   fifo_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic          head_write;
  logic [31:0]   head_addr, head_data;
  logic [7:0]    wait_cnt, wait_cnt_inc;
  logic          timeout_hit;

  assign full          = (count == DEPTH_L);
  assign empty         = (count == '0);
  assign cmd_ready_out = !full;
  assign push          = cmd_valid_in && !full;
  assign {head_write, head_addr, head_data} = fifo_mem[rd_ptr];

  assign wait_cnt_inc  = wait_cnt + 8'd1;
  assign timeout_hit   = (wait_cnt_inc == TMO_L);

  assign bus_wr_out    = (state == S_WRITE);
  assign bus_rd_out    = (state == S_READ);
  assign rsp_valid_out = (state == S_RESP);

  // Command storage; data entries need no reset, only the pointers do
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write_in, cmd_addr_in, cmd_data_in};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transaction state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a popped command always runs to completion before the next pop
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  if (bus_rd_valid_in || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus address/data, wait counter and response capture; read valid wins over timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr_out      <= '0;
      bus_data_out      <= '0;
      rsp_data_out      <= '0;
      rsp_timeout_out   <= 1'b0;
      timeout_count_out <= '0;
      wait_cnt          <= '0;
    end else begin
      if (pop) begin
        bus_addr_out <= head_addr;
        if (head_write) bus_data_out <= head_data;
      end
      if (state == S_READ)      wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt_inc;
      if (state == S_WAIT) begin
        if (bus_rd_valid_in) begin
          rsp_data_out    <= bus_data_in;
          rsp_timeout_out <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_out    <= '0;
          rsp_timeout_out <= 1'b1;
          if (timeout_count_out != 16'hFFFF) timeout_count_out <= timeout_count_out + 16'd1;
        end
      end
    end
  end
endmodule
